pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. It generalises the team's fixed 16-bit single-cycle lookahead adder in four ways: configurable width, configurable lookahead group size, configurable pipeline depth, and a subtract mode with status flags. It sits in the execute stage between the operand-select muxes and the writeback register, and can stall under writeback backpressure.

---
 rtl/pipelined_cla_adder.sv | 193 +++++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake on both sides.
// Optional saturation is built only when CLA_SAT_EN is defined.
module pipelined_cla_adder #(
   parameter int WIDTH  = 16,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovfl,
   output logic             zero,
   output logic             neg
);

   localparam int NG   = WIDTH / BLOCK;
   localparam int GPS  = NG / STAGES;
   localparam int SEGW = GPS * BLOCK;

   // Resolves one segment: returns {carry out, sum bits} using two-level lookahead.
   function automatic logic [SEGW:0] seg_add(input logic [SEGW-1:0] p,
                                             input logic [SEGW-1:0] g,
                                             input logic            ci);
      logic [GPS-1:0]  gg;
      logic [GPS-1:0]  gp;
      logic [GPS:0]    gc;
      logic [SEGW-1:0] c;
      logic            t;
      gg = '0;
      gp = '0;
      gc = '0;
      c  = '0;
      for (int k = 0; k < GPS; k++) begin
         gp[k] = &p[k*BLOCK +: BLOCK];
         for (int i = 0; i < BLOCK; i++) begin
            t = g[k*BLOCK+i];
            for (int j = i + 1; j < BLOCK; j++) t = t & p[k*BLOCK+j];
            gg[k] = gg[k] | t;
         end
      end
      for (int k = 0; k <= GPS; k++) begin
         t = ci;
         for (int m = 0; m < k; m++) t = t & gp[m];
         gc[k] = t;
         for (int m = 0; m < k; m++) begin
            t = gg[m];
            for (int n = m + 1; n < k; n++) t = t & gp[n];
            gc[k] = gc[k] | t;
         end
      end
      for (int k = 0; k < GPS; k++) begin
         for (int i = 0; i < BLOCK; i++) begin
            t = gc[k];
            for (int n = 0; n < i; n++) t = t & p[k*BLOCK+n];
            c[k*BLOCK+i] = t;
            for (int j = 0; j < i; j++) begin
               t = g[k*BLOCK+j];
               for (int n = j + 1; n < i; n++) t = t & p[k*BLOCK+n];
               c[k*BLOCK+i] = c[k*BLOCK+i] | t;
            end
         end
      end
      return {gc[GPS], p ^ c};
   endfunction

   // Boundary k feeds stage k; word holds sum bits once resolved, p bits until then.
   logic [WIDTH-1:0] word_pipe [STAGES+1];
   logic [WIDTH-1:0] g_pipe    [STAGES];
   logic             c_pipe    [STAGES+1];
   logic             vpipe     [STAGES+1];
   logic             load      [STAGES+1];
   logic [WIDTH-1:0] b_eff;

   assign b_eff        = sub ? ~b : b;
   assign word_pipe[0] = a ^ b_eff;
   assign g_pipe[0]    = a & b_eff;
   assign c_pipe[0]    = cin;
   assign vpipe[0]     = in_valid;

`ifdef CLA_SAT_EN
   logic sat_pipe [STAGES];
   assign sat_pipe[0] = sat;
`else
   logic sat_unused;
   assign sat_unused = sat;
`endif

   // A stage may load when it is empty or everything downstream of it is moving.
   always_comb begin
      load[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         load[k] = ~vpipe[k+1] | load[k+1];
      end
   end

   assign in_ready  = load[0];
   assign out_valid = vpipe[STAGES];
   assign sum       = word_pipe[STAGES];
   assign cout      = c_pipe[STAGES];

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = gi * SEGW;
      logic [SEGW:0]    res;
      logic [WIDTH-1:0] word_raw;
      logic [WIDTH-1:0] word_d;
      logic [WIDTH-1:0] word_q;
      logic             vld_q;
      logic             c_q;
      logic             take;

      assign res  = seg_add(word_pipe[gi][LO +: SEGW], g_pipe[gi][LO +: SEGW], c_pipe[gi]);
      assign take = load[gi] & vpipe[gi];

      always_comb begin
         word_raw               = word_pipe[gi];
         word_raw[LO +: SEGW]   = res[SEGW-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q  <= 1'b0;
            word_q <= '0;
            c_q    <= 1'b0;
         end else begin
            if (load[gi]) vld_q <= vpipe[gi];
            if (take) begin
               word_q <= word_d;
               c_q    <= res[SEGW];
            end
         end
      end

      assign vpipe[gi+1]     = vld_q;
      assign word_pipe[gi+1] = word_q;
      assign c_pipe[gi+1]    = c_q;

      if (gi < STAGES - 1) begin : g_mid
         logic [WIDTH-1:0] g_q;
         assign word_d = word_raw;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) g_q <= '0;
            else if (take) g_q <= g_pipe[gi];
         end
         assign g_pipe[gi+1] = g_q;
`ifdef CLA_SAT_EN
         logic sat_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sat_q <= 1'b0;
            else if (take) sat_q <= sat_pipe[gi];
         end
         assign sat_pipe[gi+1] = sat_q;
`endif
      end else begin : g_last
         logic ovfl_d, zero_d, neg_d;
         logic ovfl_q, zero_q, neg_q;
         // Carry into MSB is p_msb ^ sum_msb; overflow compares it with carry out.
         assign ovfl_d = word_pipe[gi][WIDTH-1] ^ res[SEGW-1] ^ res[SEGW];
`ifdef CLA_SAT_EN
         assign word_d = (sat_pipe[gi] & ovfl_d) ?
                         {~word_raw[WIDTH-1], {(WIDTH-1){word_raw[WIDTH-1]}}} : word_raw;
`else
         assign word_d = word_raw;
`endif
         assign zero_d = (word_d == '0);
         assign neg_d  = word_d[WIDTH-1];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovfl_q <= 1'b0;
               zero_q <= 1'b0;
               neg_q  <= 1'b0;
            end else if (take) begin
               ovfl_q <= ovfl_d;
               zero_q <= zero_d;
               neg_q  <= neg_d;
            end
         end
         assign ovfl = ovfl_q;
         assign zero = zero_q;
         assign neg  = neg_q;
      end
   end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder at WIDTH=16, BLOCK=4, STAGES=2.
module tb_pipelined_cla_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [15:0] a, b;
   logic        cin, sub, sat;
   logic        out_valid, out_ready;
   logic [15:0] sum;
   logic        cout, ovfl, zero, neg;

   int n_cmp = 0;
   int n_err = 0;

   pipelined_cla_adder #(.WIDTH(16), .BLOCK(4), .STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .sat(sat),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovfl(ovfl), .zero(zero), .neg(neg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_op(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                        input logic oc, input logic os, input logic osat,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input logic ez, input logic en);
      @(posedge clk); #1;
      in_valid = 1'b1; a = oa; b = ob; cin = oc; sub = os; sat = osat; out_ready = 1'b1;
      #1 check({tag, "_inrdy"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, "_early"}, out_valid, 0);
      @(posedge clk); #1;
      check({tag, "_ov"}, out_valid, 1);
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, cout, ec);
      check({tag, "_ovfl"}, ovfl, eo);
      check({tag, "_zero"}, zero, ez);
      check({tag, "_neg"}, neg, en);
      $display("op %s a=%h b=%h sub=%b cin=%b sat=%b -> sum=%h cout=%b ovfl=%b zero=%b neg=%b",
               tag, oa, ob, os, oc, osat, sum, cout, ovfl, zero, neg);
   endtask

   task automatic run_stall();
      logic [15:0] exp_s [5];
      logic [15:0] sum_c;
      int  sent = 0, recvd = 0, stall_left = 0, cyc = 0, extra = 0;
      bit  stall_started = 0, pass_checked = 0, xin, xout;
      exp_s = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
      @(posedge clk); #1;
      while (recvd < 5 && cyc < 40) begin
         if (out_valid && !stall_started) begin
            stall_started = 1;
            stall_left    = 3;
         end
         out_ready = (stall_left == 0);
         in_valid  = (sent < 5);
         a = 16'(16'h0100 * (sent + 1));
         b = 16'(sent + 1);
         cin = 1'b0; sub = 1'b0; sat = 1'b0;
         #1;
         if (stall_left > 0) begin
            check("stall_inrdy", in_ready, 0);
            check("stall_ov", out_valid, 1);
            check("stall_sum", sum, exp_s[recvd]);
         end else if (stall_started && !pass_checked) begin
            pass_checked = 1;
            check("full_pass_inrdy", in_ready, 1);
         end
         xin   = in_valid & in_ready;
         xout  = out_valid & out_ready;
         sum_c = sum;
         if (stall_left > 0) stall_left--;
         @(posedge clk); #1;
         if (xin) sent++;
         if (xout) begin
            check("stall_order", sum_c, exp_s[recvd]);
            $display("stall result %0d sum=%h", recvd, sum_c);
            recvd++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      check("stall_count", recvd, 5);
      for (int i = 0; i < 4; i++) begin
         #1 if (out_valid) extra++;
         @(posedge clk); #1;
      end
      check("stall_nodup", extra, 0);
   endtask

   task automatic run_reset();
      int stale = 0;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; a = 16'h0001; b = 16'h0001; cin = 0; sub = 0; sat = 0;
      @(posedge clk); #1;
      a = 16'h0002; b = 16'h0002;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("prerst_ov", out_valid, 1);
      check("prerst_sum", sum, 16'h0002);
      #2 rst_n = 1'b0;
      #1;
      check("rst_ov", out_valid, 0);
      check("rst_sum", sum, 16'h0000);
      @(posedge clk); #3 rst_n = 1'b1;
      #1 check("rst_inrdy", in_ready, 1);
      out_ready = 1'b1;
      $display("reset mid-flight: out_valid=%b sum=%h in_ready=%b", out_valid, sum, in_ready);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      check("rst_stale", stale, 0);
   endtask

   function automatic logic [20:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic mc, input logic ms, input logic msat);
      logic [15:0] bx, s;
      logic [16:0] f;
      logic        ov;
      bx = ms ? ~mb : mb;
      f  = {1'b0, ma} + {1'b0, bx} + {16'b0, mc};
      s  = f[15:0];
      ov = (ma[15] == bx[15]) && (s[15] != ma[15]);
`ifdef CLA_SAT_EN
      if (msat && ov) s = s[15] ? 16'h7FFF : 16'h8000;
`else
      if (msat) s = s;
`endif
      return {s, f[16], ov, (s == 16'h0000), s[15]};
   endfunction

   task automatic run_random(input int n);
      logic [20:0] q [$];
      logic [20:0] e, obs;
      int  sent = 0, recvd = 0, cyc = 0;
      bit  xin, xout;
      @(posedge clk); #1;
      while (recvd < n && cyc < n * 6 + 100) begin
         in_valid  = (sent < n) && ($urandom_range(3) != 0);
         a         = 16'($urandom);
         b         = 16'($urandom);
         cin       = 1'($urandom_range(1));
         sub       = 1'($urandom_range(1));
         sat       = 1'($urandom_range(1));
         out_ready = ($urandom_range(3) != 0);
         #1;
         xin  = in_valid & in_ready;
         xout = out_valid & out_ready;
         obs  = {sum, cout, ovfl, zero, neg};
         @(posedge clk); #1;
         if (xin) begin
            q.push_back(model(a, b, cin, sub, sat));
            sent++;
         end
         if (xout) begin
            if (q.size() == 0) check("rand_extra", 1, 0);
            else begin
               e = q.pop_front();
               check("rand", 32'(obs), 32'(e));
               $display("rand %0d got %h exp %h", recvd, obs, e);
            end
            recvd++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      check("rand_count", recvd, n);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 0; sub = 0; sat = 0; out_ready = 1'b1;
      @(posedge clk); @(posedge clk); #3;
      check("reset_ov", out_valid, 0);
      check("reset_sum", sum, 16'h0000);
      check("reset_flags", {cout, ovfl, zero, neg}, 4'b0000);
      check("reset_inrdy", in_ready, 1);
      rst_n = 1'b1;

      do_op("wrap", 16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 0, 1, 0);
      do_op("plain", 16'h1234, 16'h4321, 0, 0, 0, 16'h5555, 0, 0, 0, 0);
`ifdef CLA_SAT_EN
      do_op("satpos", 16'h7FFF, 16'h0001, 0, 0, 1, 16'h7FFF, 0, 1, 0, 0);
      do_op("satneg", 16'h8000, 16'hFFFF, 0, 0, 1, 16'h8000, 1, 1, 0, 1);
`else
      do_op("satpos", 16'h7FFF, 16'h0001, 0, 0, 1, 16'h8000, 0, 1, 0, 1);
      do_op("satneg", 16'h8000, 16'hFFFF, 0, 0, 1, 16'h7FFF, 1, 1, 0, 0);
`endif
      do_op("sub5m7", 16'h0005, 16'h0007, 1, 1, 0, 16'hFFFE, 0, 0, 0, 1);
      do_op("submin", 16'h8000, 16'h0001, 1, 1, 0, 16'h7FFF, 1, 1, 0, 0);

      run_stall();
      run_reset();
      run_random(600);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
